// File: rtl/demux_rr_sequencer_pkg.sv
// Shared types and constants for the round-robin enable sequencer.
package demux_rr_sequencer_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Registered grant payload that drives the demux select/enable pair.
  typedef struct packed {
    logic [IDX_W-1:0] sel;
    logic             e;
  } grant_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/demux_rr_sequencer_if.sv
// Request/grant bundle between the request sources and the sequencer.
interface demux_rr_sequencer_if;
  import demux_rr_sequencer_pkg::*;

  logic               En;
  logic [NUM_REQ-1:0] Req;
  logic [IDX_W-1:0]   Sel;
  logic               E;
  logic               Out1;
  logic               Out2;
  logic               Out3;
  logic               Out4;
  logic               Busy;

  modport master (
    output En, Req,
    input  Sel, E, Out1, Out2, Out3, Out4, Busy
  );

  modport slave (
    input  En, Req,
    output Sel, E, Out1, Out2, Out3, Out4, Busy
  );

endinterface

// File: rtl/demux_1x4.sv
// 1-to-4 enable demultiplexer: exactly one output follows E, chosen by Sel.
module demux_1x4 (
  input  logic [1:0] Sel,
  input  logic       E,
  output logic       Out1,
  output logic       Out2,
  output logic       Out3,
  output logic       Out4
);

  assign Out1 = E && (Sel == 2'd0);
  assign Out2 = E && (Sel == 2'd1);
  assign Out3 = E && (Sel == 2'd2);
  assign Out4 = E && (Sel == 2'd3);

endmodule

// File: rtl/demux_rr_sequencer_rr_pick_4.sv
// Combinational round-robin pick: first asserted request scanning from Ptr upward with wrap.
module rr_pick_4
  import demux_rr_sequencer_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  output logic               Valid,
  output logic [IDX_W-1:0]   Idx
);

  // Scan from the farthest offset down so the nearest hit to Ptr wins.
  always_comb begin
    Valid = 1'b0;
    Idx   = Ptr;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (Req[IDX_W'(Ptr + IDX_W'(i))]) begin
        Valid = 1'b1;
        Idx   = IDX_W'(Ptr + IDX_W'(i));
      end
    end
  end

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin sequencer sharing one enable line among four requesters through a demux_1x4.
module demux_rr_sequencer
  import demux_rr_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  demux_rr_sequencer_if.slave  bus
);

  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             grant_end;

  rr_pick_4 u_pick (
    .Req   (bus.Req),
    .Ptr   (ptr_q),
    .Valid (pick_valid),
    .Idx   (pick_idx)
  );

  // Any one of these closes the current grant; they all share a single exit path.
  assign grant_end = !bus.Req[grant_q.sel] || (cnt_q == HOLD_LAST) || !bus.En;

  // State, grant, pointer and counter registers; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic: arbitrate from IDLE or at the end of the gap, time-box each grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grant_d.e = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.En && pick_valid) begin
          state_d     = ST_GRANT;
          grant_d.sel = pick_idx;
          grant_d.e   = 1'b1;
          cnt_d       = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (grant_end) begin
          state_d = ST_GAP;
          ptr_d   = IDX_W'(grant_q.sel + IDX_W'(1));
          cnt_d   = CNT_ONE;
        end else begin
          grant_d.e = 1'b1;
          cnt_d     = CNT_W'(cnt_q + CNT_ONE);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (bus.En && pick_valid) begin
            state_d     = ST_GRANT;
            grant_d.sel = pick_idx;
            grant_d.e   = 1'b1;
            cnt_d       = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_ONE);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.Sel  = grant_q.sel;
  assign bus.E    = grant_q.e;
  assign bus.Busy = busy_q;

  demux_1x4 u_demux (
    .Sel  (grant_q.sel),
    .E    (grant_q.e),
    .Out1 (bus.Out1),
    .Out2 (bus.Out2),
    .Out3 (bus.Out3),
    .Out4 (bus.Out4)
  );

endmodule
